pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
- Parametrised N-stage pipeline-register chain for the RISC-V pipelined core; generalises the hand-written inter-stage flip-flops.
- Each stage carries a payload, valid bit, destination register and regwrite flag.
- Per-stage stall and flush with automatic bubble insertion.
- Built-in forwarding lookup returns the youngest in-flight stage writing a queried source register.

Parameters:
STAGES, 4, number of register boundaries (>=2); stage 0 youngest, STAGES-1 oldest
WIDTH, 64, payload bits per stage (control + data bundle)
RD_W, 5, destination/source register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  new entry offered to stage 0
in_data  in  WIDTH  payload of new entry
in_rd  in  RD_W  destination register of new entry
in_regwrite  in  1  new entry writes a register
in_ready  out  1  stage 0 accepts this cycle (= ~hold[0])
stall_req  in  STAGES  bit k: stage k must hold its contents
flush  in  STAGES  bit k: stage k becomes a bubble next edge
stage_valid  out  STAGES  valid bit of every stage
stage_rd  out  STAGES*RD_W  rd of every stage, stage k at [k*RD_W +: RD_W]
stage_regwrite  out  STAGES  regwrite of every stage (0 when invalid)
out_valid  out  1  valid of stage STAGES-1
out_data  out  WIDTH  payload of stage STAGES-1
out_rd  out  RD_W  rd of stage STAGES-1
out_regwrite  out  1  regwrite of stage STAGES-1
q_rs1, q_rs2  in  RD_W  forwarding query sources
fwd_hit1, fwd_hit2  out  1  match found for q_rs1 / q_rs2
fwd_stage1, fwd_stage2  out  $clog2(STAGES)  youngest matching stage index (0 when no hit)

Behaviour:
- Reset (async, rst=1): all valid, regwrite, rd, payload = 0 immediately. out_valid=0, in_ready=1 (if stall_req=0), fwd_hit*=0. Release is synchronous to the next clk edge.
- hold[k] = OR(stall_req[j]) for j>=k. A stall in an older stage freezes every younger stage.
- Per stage k at each rising edge, priority order:
  1. flush[k]=1: bubble (valid=0, regwrite=0, rd=0, payload=0). Flush beats hold.
  2. hold[k]=1: keep contents.
  3. k>0 and hold[k-1]=1: bubble. This is the only bubble-insertion point.
  4. Otherwise load from stage k-1 (k=0: load in_* with valid=in_valid).
- Stage 0 with in_valid=0 and not held loads a bubble.
- regwrite stored as in_regwrite & in_valid; invalid stages never report regwrite.
- Latency: entry accepted at edge t appears on out_* after edge t+STAGES-1 with no stalls. Throughput 1/cycle.
- in_ready is combinational from stall_req only. A flush of stage 0 alone still accepts and discards (flush wins).
- Oldest stage hold: stall_req[STAGES-1]=1 freezes the whole chain; out_* stable; in_ready=0.
- Forwarding: hit when stage_valid[k] & stage_regwrite[k] & stage_rd[k]==q_rs & q_rs!=0.
  - Lowest-index (youngest) hit wins.
  - Purely combinational from registers; no dependency on in_*.
- Outputs are registered state plus combinational hold/forward logic; no comb path from in_data to any output.

Optional Feature:
PIPE_PERF_CNT_EN:
- When defined, adds outputs stall_cycles[31:0] and bubble_cycles[31:0]. Both reset to 0 and wrap at 2^32.
- stall_cycles increments each cycle with in_ready=0.
- bubble_cycles increments each cycle out_valid=0 after the first valid entry has reached the output since reset.
- When undefined: ports and counters absent; core behaviour identical.

Test Plan:
- STAGES=4, stream payloads 1..5 with rd 1..5, no stall/flush -> out_data=1 three edges after acceptance, then 2,3,4,5 on consecutive cycles; out_valid high 5 cycles.
- stall_req=4'b0100 for 2 cycles during stream -> stages 0-2 frozen, stage 3 receives 2 bubbles, in_ready=0 for 2 cycles, output sequence has no loss or duplication.
- stall_req=4'b0010 with flush=4'b0011 same cycle -> stages 0,1 valid=0 next cycle, stage 2 bubble, stage 3 advances normally.
- rd=5 regwrite in stages 1 and 3, q_rs1=5 -> fwd_hit1=1, fwd_stage1=1. q_rs2=0 with rd=0 in flight -> fwd_hit2=0. rd=7 with regwrite=0 -> no hit.
- Assert rst mid-stream, asynchronous to clk -> all stage_valid=0 and out_valid=0 before next edge; first entry after release exits after STAGES-1 edges.
- PIPE_PERF_CNT_EN defined, 3-cycle stall_req[0] -> stall_cycles=3; 2 cycles of idle input after output starts -> bubble_cycles=2.

Source files
------------

// File: rtl/pipe_stage_chain_if.sv
// Handshake bundle for pipe_stage_chain.
// Carries the producer-side entry offer (in_*) and the oldest stage's contents (out_*).
// The slave modport is the pipeline. The master modport is whatever feeds and drains it.
interface pipe_stage_chain_if #(
    parameter int WIDTH = 64,
    parameter int RD_W  = 5
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [RD_W-1:0]  in_rd;
    logic             in_regwrite;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [RD_W-1:0]  out_rd;
    logic             out_regwrite;

    modport master (
        output in_valid, in_data, in_rd, in_regwrite,
        input  in_ready, out_valid, out_data, out_rd, out_regwrite
    );

    modport slave (
        input  in_valid, in_data, in_rd, in_regwrite,
        output in_ready, out_valid, out_data, out_rd, out_regwrite
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// N-stage pipeline register chain with per-stage stall/flush, automatic bubble
// insertion behind a stalled stage, and a youngest-first forwarding lookup.
// Stage 0 is the youngest and STAGES-1 is the oldest.
// Optional macro PIPE_PERF_CNT_EN adds the stall_cycles and bubble_cycles counters.
module pipe_stage_chain #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 64,
    parameter int RD_W   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    pipe_stage_chain_if.slave          bus,
    input  logic [STAGES-1:0]          stall_req,
    input  logic [STAGES-1:0]          flush,
    output logic [STAGES-1:0]          stage_valid,
    output logic [STAGES*RD_W-1:0]     stage_rd,
    output logic [STAGES-1:0]          stage_regwrite,
    input  logic [RD_W-1:0]            q_rs1,
    input  logic [RD_W-1:0]            q_rs2,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic [$clog2(STAGES)-1:0]  fwd_stage1,
    output logic [$clog2(STAGES)-1:0]  fwd_stage2
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]                stall_cycles,
    output logic [31:0]                bubble_cycles
`endif
);
    localparam int SW = $clog2(STAGES);

    // A stage is held when it or any older stage requests a stall.
    logic [STAGES-1:0] hold;
    // Flattened view of every stage's registers, so each stage can read its predecessor.
    logic [STAGES-1:0] stg_valid;
    logic [STAGES-1:0] stg_rw;
    logic [RD_W-1:0]   stg_rd   [STAGES];
    logic [WIDTH-1:0]  stg_data [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic             src_valid;
            logic             src_rw;
            logic             prev_hold;
            logic [RD_W-1:0]  src_rd;
            logic [WIDTH-1:0] src_data;
            logic             valid_q;
            logic             valid_d;
            logic             rw_q;
            logic             rw_d;
            logic [RD_W-1:0]  rd_q;
            logic [RD_W-1:0]  rd_d;
            logic [WIDTH-1:0] data_q;
            logic [WIDTH-1:0] data_d;

            assign hold[gi] = |stall_req[STAGES-1:gi];

            if (gi == 0) begin : g_head
                // An empty offer enters as a clean bubble, with its fields zeroed.
                assign src_valid = bus.in_valid;
                assign src_rw    = bus.in_valid & bus.in_regwrite;
                assign src_rd    = bus.in_valid ? bus.in_rd : '0;
                assign src_data  = bus.in_valid ? bus.in_data : '0;
                assign prev_hold = 1'b0;
            end else begin : g_body
                assign src_valid = stg_valid[gi-1];
                assign src_rw    = stg_rw[gi-1];
                assign src_rd    = stg_rd[gi-1];
                assign src_data  = stg_data[gi-1];
                assign prev_hold = hold[gi-1];
            end

            // Next-state priority: flush, then hold, then bubble behind a held predecessor, then advance.
            always_comb begin
                valid_d = valid_q;
                rw_d    = rw_q;
                rd_d    = rd_q;
                data_d  = data_q;
                if (flush[gi] || (!hold[gi] && prev_hold)) begin
                    valid_d = 1'b0;
                    rw_d    = 1'b0;
                    rd_d    = '0;
                    data_d  = '0;
                end else if (!hold[gi]) begin
                    valid_d = src_valid;
                    rw_d    = src_rw;
                    rd_d    = src_rd;
                    data_d  = src_data;
                end
            end

            // Stage register, which is cleared immediately when rst is asserted.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    rw_q    <= 1'b0;
                    rd_q    <= '0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    rw_q    <= rw_d;
                    rd_q    <= rd_d;
                    data_q  <= data_d;
                end
            end

            assign stg_valid[gi]                = valid_q;
            assign stg_rw[gi]                   = rw_q;
            assign stg_rd[gi]                   = rd_q;
            assign stg_data[gi]                 = data_q;
            assign stage_rd[gi*RD_W +: RD_W]    = rd_q;
        end
    endgenerate

    assign stage_valid      = stg_valid;
    assign stage_regwrite   = stg_rw;
    assign bus.in_ready     = ~hold[0];
    assign bus.out_valid    = stg_valid[STAGES-1];
    assign bus.out_data     = stg_data[STAGES-1];
    assign bus.out_rd       = stg_rd[STAGES-1];
    assign bus.out_regwrite = stg_rw[STAGES-1];

    // Forwarding lookup: scan from oldest to youngest so the youngest match is written last and wins.
    always_comb begin
        fwd_hit1   = 1'b0;
        fwd_hit2   = 1'b0;
        fwd_stage1 = '0;
        fwd_stage2 = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (stg_valid[k] && stg_rw[k] && (q_rs1 != '0) && (stg_rd[k] == q_rs1)) begin
                fwd_hit1   = 1'b1;
                fwd_stage1 = SW'(k);
            end
            if (stg_valid[k] && stg_rw[k] && (q_rs2 != '0) && (stg_rd[k] == q_rs2)) begin
                fwd_hit2   = 1'b1;
                fwd_stage2 = SW'(k);
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] bubble_cnt_q;
    logic [31:0] bubble_cnt_d;
    logic        seen_out_q;
    logic        seen_out_d;

    // Count stalled-input cycles, and count output gaps once the first result has appeared.
    always_comb begin
        stall_cnt_d  = hold[0] ? stall_cnt_q + 32'd1 : stall_cnt_q;
        bubble_cnt_d = (seen_out_q && !stg_valid[STAGES-1]) ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
        seen_out_d   = seen_out_q | stg_valid[STAGES-1];
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            seen_out_q   <= 1'b0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            seen_out_q   <= seen_out_d;
        end
    end

    assign stall_cycles  = stall_cnt_q;
    assign bubble_cycles = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain.
// The stimulus process drives inputs just after each rising edge.
// It advances an entry-level reference model and pushes each accepted entry into an expected queue.
// A monitor checks every stage on the falling edge.
// It pops the queue whenever the oldest entry leaves the pipe.
module tb_pipe_stage_chain;
    localparam int S = 4;
    localparam int W = 64;
    localparam int R = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_stage_chain_if #(.WIDTH(W), .RD_W(R)) bus ();

    logic [S-1:0]         stall_req;
    logic [S-1:0]         flush;
    logic [S-1:0]         stage_valid;
    logic [S*R-1:0]       stage_rd;
    logic [S-1:0]         stage_regwrite;
    logic [R-1:0]         q_rs1;
    logic [R-1:0]         q_rs2;
    logic                 fwd_hit1;
    logic                 fwd_hit2;
    logic [$clog2(S)-1:0] fwd_stage1;
    logic [$clog2(S)-1:0] fwd_stage2;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0]          stall_cycles;
    logic [31:0]          bubble_cycles;
`endif

    pipe_stage_chain #(.STAGES(S), .WIDTH(W), .RD_W(R)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .stall_req      (stall_req),
        .flush          (flush),
        .stage_valid    (stage_valid),
        .stage_rd       (stage_rd),
        .stage_regwrite (stage_regwrite),
        .q_rs1          (q_rs1),
        .q_rs2          (q_rs2),
        .fwd_hit1       (fwd_hit1),
        .fwd_hit2       (fwd_hit2),
        .fwd_stage1     (fwd_stage1),
        .fwd_stage2     (fwd_stage2)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .bubble_cycles  (bubble_cycles)
`endif
    );

    typedef struct {
        int           id;
        logic [W-1:0] data;
        logic [R-1:0] rd;
        logic         rw;
        int           acc;
        bit           lat;
    } ent_t;

    ent_t        exp_q[$];
    bit          m_valid[S];
    ent_t        m_ent[S];
    int          cyc = 0;
    int          next_id = 0;
    int          checks = 0;
    int          errors = 0;
    bit          lat_phase = 0;
    int unsigned m_stall = 0;
    int unsigned m_bubble = 0;
    bit          m_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < S; k++) m_valid[k] = 0;
        exp_q.delete();
        m_seen   = 0;
        m_stall  = 0;
        m_bubble = 0;
    endtask

    // Entry-level model of one clock edge.
    // Each slot holds an entry, or nothing.
    // Any entry that vanishes without leaving through the output is dropped from the expected queue.
    task automatic model_step();
        bit   h[S];
        bit   nv[S];
        ent_t ne[S];
        ent_t e;
        cyc++;
        if (rst) begin
            clear_model();
            return;
        end
        if (stall_req != '0) m_stall++;
        if (m_seen && !m_valid[S-1]) m_bubble++;
        if (m_valid[S-1]) m_seen = 1;
        for (int k = 0; k < S; k++) h[k] = ((stall_req >> k) != '0);
        for (int k = 0; k < S; k++) begin
            nv[k] = m_valid[k];
            ne[k] = m_ent[k];
            if (flush[k]) nv[k] = 0;
            else if (h[k]) nv[k] = m_valid[k];
            else if (k > 0 && h[k-1]) nv[k] = 0;
            else if (k == 0) begin
                nv[0] = bus.in_valid;
                if (bus.in_valid) begin
                    e.id = next_id++; e.data = bus.in_data; e.rd = bus.in_rd;
                    e.rw = bus.in_regwrite; e.acc = cyc; e.lat = lat_phase;
                    ne[0] = e;
                    exp_q.push_back(e);
                end
            end else begin
                nv[k] = m_valid[k-1];
                ne[k] = m_ent[k-1];
            end
        end
        for (int k = 0; k < S; k++) begin
            if (m_valid[k]) begin
                bit found = 0;
                bit departed = (k == S-1) && !h[k] && !flush[k];
                for (int j = 0; j < S; j++) if (nv[j] && ne[j].id == m_ent[k].id) found = 1;
                if (!found && !departed) begin
                    for (int i = 0; i < exp_q.size(); i++)
                        if (exp_q[i].id == m_ent[k].id) begin exp_q.delete(i); break; end
                end
            end
        end
        for (int k = 0; k < S; k++) begin m_valid[k] = nv[k]; m_ent[k] = ne[k]; end
    endtask

    function automatic int ref_fwd(input logic [R-1:0] q);
        if (q == '0) return -1;
        for (int k = 0; k < S; k++)
            if (m_valid[k] && m_ent[k].rw && m_ent[k].rd == q) return k;
        return -1;
    endfunction

    logic [S-1:0]   e_valid;
    logic [S-1:0]   e_rw;
    logic [S*R-1:0] e_rd;
    int             f1;
    int             f2;
    ent_t           pe;

    // Monitor: compares every stage on the falling edge, and checks each departing entry against the queue.
    always @(negedge clk) begin
        for (int k = 0; k < S; k++) begin
            e_valid[k]       = m_valid[k];
            e_rw[k]          = m_valid[k] & m_ent[k].rw;
            e_rd[k*R +: R]   = m_valid[k] ? m_ent[k].rd : '0;
        end
        chk("in_ready", 64'(bus.in_ready), 64'(stall_req == '0));
        chk("stage_valid", 64'(stage_valid), 64'(e_valid));
        chk("stage_regwrite", 64'(stage_regwrite), 64'(e_rw));
        chk("stage_rd", 64'(stage_rd), 64'(e_rd));
        chk("out_data", bus.out_data, m_valid[S-1] ? m_ent[S-1].data : 64'd0);
        f1 = ref_fwd(q_rs1);
        f2 = ref_fwd(q_rs2);
        chk("fwd1", {62'd0, fwd_hit1, 1'b0} | 64'(fwd_stage1) << 8,
            {62'd0, f1 >= 0, 1'b0} | 64'(f1 >= 0 ? f1 : 0) << 8);
        chk("fwd2", {62'd0, fwd_hit2, 1'b0} | 64'(fwd_stage2) << 8,
            {62'd0, f2 >= 0, 1'b0} | 64'(f2 >= 0 ? f2 : 0) << 8);
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        chk("bubble_cycles", 64'(bubble_cycles), 64'(m_bubble));
`endif
        if (!rst && m_valid[S-1] && !stall_req[S-1] && !flush[S-1]) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: got output with empty expected queue, required none");
            end else begin
                pe = exp_q.pop_front();
                $display("OUT id=%0d data=%h rd=%0d rw=%0d cyc=%0d", pe.id, bus.out_data,
                         bus.out_rd, bus.out_regwrite, cyc);
                chk("out_valid", 64'(bus.out_valid), 64'd1);
                chk("out_payload", bus.out_data, pe.data);
                chk("out_rd", 64'(bus.out_rd), 64'(pe.rd));
                chk("out_regwrite", 64'(bus.out_regwrite), 64'(pe.rw));
                if (pe.lat) chk("latency", 64'(cyc - pe.acc), 64'(S - 1));
            end
        end
    end

    task automatic drive(input bit iv, input logic [W-1:0] d, input logic [R-1:0] rd, input bit rw,
                         input logic [S-1:0] st, input logic [S-1:0] fl,
                         input logic [R-1:0] q1, input logic [R-1:0] q2);
        bus.in_valid = iv; bus.in_data = d; bus.in_rd = rd; bus.in_regwrite = rw;
        stall_req = st; flush = fl; q_rs1 = q1; q_rs2 = q2;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        int p;
        drive(0, '0, '0, 0, '0, '0, '0, '0);
        rst = 1'b1;
        #1;
        chk("reset_valid", 64'(stage_valid), 64'd0);
        chk("reset_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) step();
        rst = 1'b0;

        // Plain stream 1..5, with the latency of every entry checked.
        lat_phase = 1;
        for (int i = 1; i <= 5; i++) begin
            drive(1, 64'(i), R'(i), 1, '0, '0, 5'd3, 5'd1);
            step();
        end
        lat_phase = 0;
        drive(0, '0, '0, 0, '0, '0, '0, '0);
        repeat (6) step();

        // Stream with a 2-cycle stall of stage 2. The offer is held until it is accepted.
        p = 1;
        for (int c = 0; c < 12; c++) begin
            logic [S-1:0] st;
            st = (c == 3 || c == 4) ? 4'b0100 : 4'b0000;
            drive(p <= 8, 64'(p + 16), R'(p), 1, st, '0, 5'd2, 5'd4);
            step();
            if (st == '0 && p <= 8) p++;
        end

        // Stall of stage 1 together with a flush of stages 0 and 1.
        for (int c = 0; c < 4; c++) begin
            drive(1, 64'(c + 40), R'(c + 1), 1, '0, '0, '0, '0);
            step();
        end
        drive(1, 64'd99, 5'd9, 1, 4'b0010, 4'b0011, '0, '0);
        step();
        drive(0, '0, '0, 0, '0, '0, '0, '0);
        repeat (6) step();

        // Forwarding: rd=5 sits in stages 1 and 3, and rd=0 and rd=7 entries are queried.
        drive(1, 64'd1, 5'd5, 1, '0, '0, 5'd5, 5'd0); step();
        drive(1, 64'd2, 5'd7, 0, '0, '0, 5'd5, 5'd0); step();
        drive(1, 64'd3, 5'd5, 1, '0, '0, 5'd5, 5'd7); step();
        drive(1, 64'd4, 5'd0, 1, '0, '0, 5'd5, 5'd0); step();
        drive(0, '0, '0, 0, '0, '0, 5'd5, 5'd7);
        repeat (5) step();

        // Asynchronous reset asserted mid-stream, away from the clock edge.
        for (int c = 0; c < 3; c++) begin
            drive(1, 64'(c + 70), R'(c + 2), 1, '0, '0, '0, '0);
            step();
        end
        #2 rst = 1'b1;
        clear_model();
        #1;
        chk("async_rst_valid", 64'(stage_valid), 64'd0);
        chk("async_rst_out", 64'(bus.out_valid), 64'd0);
        step();
        rst = 1'b0;
        lat_phase = 1;
        drive(1, 64'hABCD, 5'd3, 1, '0, '0, '0, '0); step();
        drive(0, '0, '0, 0, '0, '0, '0, '0);
        lat_phase = 0;
        repeat (5) step();

        // Counter scenario: a 3-cycle stall of stage 0, then output gaps after a short stream.
        drive(0, '0, '0, 0, 4'b0001, '0, '0, '0);
        repeat (3) step();
        drive(1, 64'd5, 5'd5, 1, '0, '0, '0, '0); step();
        drive(0, '0, '0, 0, '0, '0, '0, '0);
        repeat (6) step();

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            logic [S-1:0] st;
            logic [S-1:0] fl;
            st = ($urandom_range(0, 99) < 15) ? S'($urandom) : '0;
            fl = ($urandom_range(0, 99) < 8) ? S'($urandom) : '0;
            drive($urandom_range(0, 99) < 70, {$urandom, $urandom}, R'($urandom_range(0, 7)),
                  1'($urandom), st, fl, R'($urandom_range(0, 7)), R'($urandom_range(0, 7)));
            step();
        end

        // Drain the pipe, and confirm that nothing is left outstanding.
        drive(0, '0, '0, 0, '0, '0, '0, '0);
        repeat (S + 4) step();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
